uart_tx_sched: RTL and testbench
================================

UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of byte requesters sharing one UART transmitter (2..8).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 64, cycles allowed for tx_busy to rise after a load pulse.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-005 SHALL have port req_valid  input  NREQ  per-requester byte pending; held with req_data until matching req_ready.
REQ-006 SHALL have port req_data  input  8*NREQ  byte of requester i on bits [8i+7:8i].
REQ-007 SHALL have port req_ready  output  NREQ  one-hot, one-cycle accept pulse.
REQ-008 SHALL have port tx_data  output  8  byte to transmitter P_DATA input.
REQ-009 SHALL have port tx_data_valid  output  1  one-cycle load pulse to transmitter.
REQ-010 SHALL have port tx_busy  input  1  transmitter frame in progress.
REQ-011 SHALL have port grant_id  output  clog2(NREQ)  index of the current or last granted requester.
REQ-012 SHALL have port sched_busy  output  1  high in every state except IDLE.
REQ-013 SHALL have port timeout_err  output  1  one-cycle pulse on load timeout.

Function
REQ-014 SHALL implement FSM states IDLE, LOAD, WAIT_BUSY and WAIT_DONE.
REQ-015 IDLE -> LOAD SHALL occur when any req_valid bit is high and tx_busy is low; grant_id and tx_data are registered on that edge.
REQ-016 Grant SHALL be round-robin: search starts at (last grant + 1) mod NREQ and wraps; after reset the search starts at index 0.
REQ-017 In LOAD, tx_data_valid SHALL be 1 and req_ready[grant_id] SHALL be 1 for exactly one cycle, then the FSM SHALL go to WAIT_BUSY.
REQ-018 WAIT_BUSY -> WAIT_DONE SHALL occur when tx_busy is 1.
REQ-019 WAIT_DONE -> IDLE SHALL occur when tx_busy is 0.
REQ-020 Latency from req_valid rising in IDLE to tx_data_valid SHALL be 1 cycle.
REQ-021 The minimum spacing between consecutive tx_data_valid pulses SHALL be (busy duration + 3) cycles.
REQ-022 tx_data SHALL hold the last loaded byte until the next grant.
REQ-023 A requester dropping req_valid after it has been granted SHALL NOT affect the byte in flight.
REQ-024 If tx_busy is already high while IDLE, the block SHALL NOT grant until tx_busy is low.
REQ-025 A requester that keeps req_valid high after req_ready SHALL be treated as a new request and re-enter arbitration behind all other pending requesters.
REQ-026 With only one requester active, that requester SHALL be granted every frame.

Reset
REQ-027 Asserting rst in any state SHALL immediately force state IDLE, req_ready=0, tx_data_valid=0, tx_data=8'h00, grant_id=0, sched_busy=0, timeout_err=0, round-robin pointer=0, and timeout counter=0.
REQ-028 Reset mid-frame SHALL drop the in-flight grant without issuing req_ready afterwards.

Configuration
REQ-029 With macro UART_TX_SCHED_TIMEOUT_EN defined, a counter SHALL run in WAIT_BUSY; if tx_busy stays 0 for TIMEOUT_CYC cycles, timeout_err SHALL pulse for one cycle and the FSM SHALL return to IDLE, with the byte counted as consumed.
REQ-030 Without UART_TX_SCHED_TIMEOUT_EN, timeout_err SHALL be tied 0 and WAIT_BUSY SHALL wait indefinitely.

Structure
REQ-031 Shared package uart_pkg SHALL hold the scheduler state typedef, the byte width constant (8), and the default NREQ.
REQ-032 Round-robin selection SHALL be a sub-module uart_rr_arb (inputs: request vector and pointer; outputs: one-hot grant and index).

Verification
REQ-033 With NREQ=4, req_valid=4'b0001, req_data[7:0]=8'hA5, and tx_busy high for 10 cycles after the load: tx_data=8'hA5, req_ready=4'b0001, and tx_data_valid pulse 1 cycle after request.
REQ-034 With req_valid=4'b1111 held continuously and a busy model: grant order 0,1,2,3,0 with exactly one req_ready pulse each.
REQ-035 With tx_busy=1 while req_valid=4'b0100 in IDLE: no tx_data_valid until tx_busy falls, then grant_id=2.
REQ-036 Asserting rst in WAIT_DONE, then requesting 4'b1000: all outputs at reset values during rst; first grant afterwards is index 3 with the search starting from 0.
REQ-037 With UART_TX_SCHED_TIMEOUT_EN and TIMEOUT_CYC=64, tx_busy never asserted: timeout_err pulses 64 cycles after the load, FSM returns to IDLE, and next requester is served.
REQ-038 Without the macro and the same stimulus: timeout_err stays 0 and sched_busy stays 1.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module  : uart_pkg
// Purpose : Shared definitions for the UART transmit scheduler. It holds the
//           scheduler state type, the byte width, and the default number of
//           requesters.
// Ports   : none (package)
// Config  : UART_TX_SCHED_TIMEOUT_EN (used by uart_tx_sched, not here)
// Revision: 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int c_BYTE_W       = 8;
    localparam int c_DEFAULT_NREQ = 4;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_LOAD      = 2'd1,
        S_WAIT_BUSY = 2'd2,
        S_WAIT_DONE = 2'd3
    } sched_state_t;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_rr_arb.sv
`default_nettype none
// ============================================================================
// Module  : uart_rr_arb
// Purpose : Combinational round-robin selector. The search begins at index
//           i_ptr and wraps. The first asserted request wins.
// Ports   : i_req  - request vector
//           i_ptr  - index where the search starts
//           o_gnt  - one-hot grant (all zero when no request is set)
//           o_idx  - index of the granted request
//           o_any  - at least one request is asserted
// Revision: 1.0 - initial release
// ============================================================================
module uart_rr_arb #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         i_req,
    input  logic [$clog2(NREQ)-1:0] i_ptr,
    output logic [NREQ-1:0]         o_gnt,
    output logic [$clog2(NREQ)-1:0] o_idx,
    output logic                    o_any
);
    localparam int             c_IW = $clog2(NREQ);
    localparam logic [c_IW:0]  c_N  = (c_IW + 1)'(NREQ);

    logic [2*NREQ-1:0] w_dbl;
    logic [NREQ-1:0]   w_rot;
    logic [c_IW-1:0]   w_off;
    logic [c_IW:0]     w_sum;

    // Rotate the requests so that bit 0 corresponds to the pointer position.
    assign w_dbl = {i_req, i_req} >> i_ptr;
    assign w_rot = w_dbl[NREQ-1:0];

    // Scan from the highest offset down, so the lowest set offset wins.
    always_comb begin
        w_off = '0;
        for (int off = NREQ - 1; off >= 0; off--) begin
            if (w_rot[off]) begin
                w_off = c_IW'(off);
            end
        end
    end

    // Convert the offset back to an absolute index, wrapping modulo NREQ.
    assign w_sum = {1'b0, i_ptr} + {1'b0, w_off};
    assign o_idx = (w_sum >= c_N) ? (w_sum[c_IW-1:0] - c_N[c_IW-1:0])
                                  : w_sum[c_IW-1:0];
    assign o_any = |i_req;
    assign o_gnt = o_any ? ({{(NREQ-1){1'b0}}, 1'b1} << o_idx) : '0;

endmodule : uart_rr_arb
`default_nettype wire

// File: rtl/uart_tx_sched.sv
`default_nettype none
// ============================================================================
// Module  : uart_tx_sched
// Purpose : Shares one UART transmitter among NREQ byte requesters using
//           round-robin arbitration. A grant produces a one-cycle load pulse
//           and a req_ready pulse. The FSM then follows tx_busy through the
//           frame.
// Ports   : clk, rst         - clock, async active-high reset
//           req_valid/data   - per-requester pending byte (8 bits each)
//           req_ready        - one-hot accept pulse
//           tx_data/valid    - byte and load pulse to the transmitter
//           tx_busy          - transmitter frame in progress
//           grant_id         - current or last granted requester
//           sched_busy       - FSM not in IDLE
//           timeout_err      - pulse when tx_busy never rose after a load
// Config  : UART_TX_SCHED_TIMEOUT_EN - enables the WAIT_BUSY timeout; when
//           it is undefined, timeout_err is tied low.
// Revision: 1.0 - initial release
// ============================================================================
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int NREQ        = c_DEFAULT_NREQ,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [c_BYTE_W*NREQ-1:0] req_data,
    output logic [NREQ-1:0]          req_ready,
    output logic [c_BYTE_W-1:0]      tx_data,
    output logic                     tx_data_valid,
    input  logic                     tx_busy,
    output logic [$clog2(NREQ)-1:0]  grant_id,
    output logic                     sched_busy,
    output logic                     timeout_err
);
    localparam int              c_IW   = $clog2(NREQ);
    localparam logic [c_IW-1:0] c_LAST = c_IW'(NREQ - 1);

    sched_state_t          r_state;
    logic [NREQ-1:0]       r_req_ready;
    logic [c_BYTE_W-1:0]   r_tx_data;
    logic                  r_tx_valid;
    logic [c_IW-1:0]       r_grant_id;
    logic                  r_sched_busy;
    logic [c_IW-1:0]       r_ptr;

    logic [NREQ-1:0]       w_gnt;
    logic [c_IW-1:0]       w_idx;
    logic                  w_any;
    logic [c_BYTE_W-1:0]   w_byte [NREQ];

    // Split the flat data bus into per-requester bytes.
    for (genvar g = 0; g < NREQ; g++) begin : g_bytes
        assign w_byte[g] = req_data[g*c_BYTE_W +: c_BYTE_W];
    end

    uart_rr_arb #(
        .NREQ (NREQ)
    ) u_arb (
        .i_req (req_valid),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx),
        .o_any (w_any)
    );

`ifdef UART_TX_SCHED_TIMEOUT_EN
    localparam int             c_TW      = $clog2(TIMEOUT_CYC);
    // The load cycle counts as the first cycle of the window, so the error
    // is registered in the cycle TIMEOUT_CYC after the load pulse.
    localparam logic [c_TW-1:0] c_TO_LAST = c_TW'(TIMEOUT_CYC - 2);
    logic [c_TW-1:0] r_to_cnt;
    logic            r_timeout_err;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_req_ready  <= '0;
            r_tx_data    <= '0;
            r_tx_valid   <= 1'b0;
            r_grant_id   <= '0;
            r_sched_busy <= 1'b0;
            r_ptr        <= '0;
`ifdef UART_TX_SCHED_TIMEOUT_EN
            r_to_cnt      <= '0;
            r_timeout_err <= 1'b0;
`endif
        end else begin
            r_req_ready <= '0;
            r_tx_valid  <= 1'b0;
`ifdef UART_TX_SCHED_TIMEOUT_EN
            r_timeout_err <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (w_any && !tx_busy) begin
                        r_state      <= S_LOAD;
                        r_sched_busy <= 1'b1;
                        r_req_ready  <= w_gnt;
                        r_tx_valid   <= 1'b1;
                        r_tx_data    <= w_byte[w_idx];
                        r_grant_id   <= w_idx;
                        // The next search starts just past the winner, so a
                        // requester that holds valid goes behind the others.
                        r_ptr        <= (w_idx == c_LAST) ? '0 : w_idx + 1'b1;
                    end
                end
                S_LOAD: begin
                    r_state <= S_WAIT_BUSY;
`ifdef UART_TX_SCHED_TIMEOUT_EN
                    r_to_cnt <= '0;
`endif
                end
                S_WAIT_BUSY: begin
                    if (tx_busy) begin
                        r_state <= S_WAIT_DONE;
`ifdef UART_TX_SCHED_TIMEOUT_EN
                    end else if (r_to_cnt == c_TO_LAST) begin
                        // Drop the frame and treat the byte as consumed.
                        r_state       <= S_IDLE;
                        r_sched_busy  <= 1'b0;
                        r_timeout_err <= 1'b1;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
`endif
                    end
                end
                S_WAIT_DONE: begin
                    if (!tx_busy) begin
                        r_state      <= S_IDLE;
                        r_sched_busy <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_sched_busy <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready     = r_req_ready;
    assign tx_data       = r_tx_data;
    assign tx_data_valid = r_tx_valid;
    assign grant_id      = r_grant_id;
    assign sched_busy    = r_sched_busy;
`ifdef UART_TX_SCHED_TIMEOUT_EN
    assign timeout_err   = r_timeout_err;
`else
    assign timeout_err   = 1'b0;
`endif

endmodule : uart_tx_sched
`default_nettype wire

// File: tb/tb_uart_tx_sched.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_tx_sched
// Purpose : Self-checking bench for uart_tx_sched (NREQ=4, TIMEOUT_CYC=64).
//           It applies a table of directed arbitration vectors and then
//           hand-written reset, busy-hold and timeout sequences.
// Config  : UART_TX_SCHED_TIMEOUT_EN selects the expected timeout behaviour.
// Revision: 1.0 - initial release
// ============================================================================
module tb_uart_tx_sched;

    localparam logic [31:0] c_DATA = 32'hD4C3_B2A5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data  = c_DATA;
    logic [3:0]  req_ready;
    logic [7:0]  tx_data;
    logic        tx_data_valid;
    logic        tx_busy = 1'b0;
    logic [1:0]  grant_id;
    logic        sched_busy;
    logic        timeout_err;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    uart_tx_sched #(
        .NREQ        (4),
        .TIMEOUT_CYC (64)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .tx_data       (tx_data),
        .tx_data_valid (tx_data_valid),
        .tx_busy       (tx_busy),
        .grant_id      (grant_id),
        .sched_busy    (sched_busy),
        .timeout_err   (timeout_err)
    );

    typedef struct {
        logic [3:0] req;
        int         d;
        int         lat;
        logic [1:0] id;
        logic [7:0] dat;
    } vec_t;

    vec_t tbl [14];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (tx_data_valid !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    // Transmitter model: busy rises the cycle after the load and stays high for d cycles.
    task automatic do_frame(input logic [3:0] req, input int d, input int exp_lat,
                            input logic [1:0] exp_id, input logic [7:0] exp_dat);
        int         lat;
        logic [3:0] oh;
        oh        = 4'b0001 << exp_id;
        req_valid = req;
        wait_valid(lat);
        chk("latency",   lat,       exp_lat);
        chk("tx_data",   tx_data,   {24'h0, exp_dat});
        chk("grant_id",  grant_id,  {30'h0, exp_id});
        chk("req_ready", req_ready, {28'h0, oh});
        tick();
        chk("single_pulse", {27'h0, req_ready, tx_data_valid}, 32'h0);
        tx_busy = 1'b1;
        repeat (d) tick();
        tx_busy = 1'b0;
    endtask

    task automatic finish_frame(input int d);
        tick();
        tx_busy = 1'b1;
        repeat (d) tick();
        tx_busy   = 1'b0;
        req_valid = '0;
        repeat (3) tick();
    endtask

    function automatic logic [31:0] outs();
        return {16'h0, req_ready, tx_data_valid, tx_data, grant_id, sched_busy, timeout_err};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int cnt;
        int bad_to;
        int bad_sb;

        tbl[0]  = '{4'b1111, 3,  1, 2'd0, 8'hA5};
        tbl[1]  = '{4'b1111, 3,  2, 2'd1, 8'hB2};
        tbl[2]  = '{4'b1111, 3,  2, 2'd2, 8'hC3};
        tbl[3]  = '{4'b1111, 3,  2, 2'd3, 8'hD4};
        tbl[4]  = '{4'b1111, 3,  2, 2'd0, 8'hA5};
        tbl[5]  = '{4'b0001, 10, 2, 2'd0, 8'hA5};
        tbl[6]  = '{4'b0001, 10, 2, 2'd0, 8'hA5};
        tbl[7]  = '{4'b1010, 2,  2, 2'd1, 8'hB2};
        tbl[8]  = '{4'b1010, 2,  2, 2'd3, 8'hD4};
        tbl[9]  = '{4'b1010, 2,  2, 2'd1, 8'hB2};
        tbl[10] = '{4'b0101, 1,  2, 2'd2, 8'hC3};
        tbl[11] = '{4'b0101, 1,  2, 2'd0, 8'hA5};
        tbl[12] = '{4'b1001, 5,  2, 2'd3, 8'hD4};
        tbl[13] = '{4'b1001, 5,  2, 2'd0, 8'hA5};

        // Reset state
        repeat (2) tick();
        chk("reset_outputs", outs(), 32'h0);
        rst = 1'b0;
        tick();
        chk("idle_after_reset", outs(), 32'h0);

        // Table: round-robin order, single requester, mixed patterns
        foreach (tbl[i]) begin
            do_frame(tbl[i].req, tbl[i].d, tbl[i].lat, tbl[i].id, tbl[i].dat);
        end

        // tx_data holds through a dropped request and changed source data
        req_valid = 4'b0100;
        wait_valid(lat);
        chk("hold_grant", {30'h0, grant_id}, 32'd2);
        tick();
        req_valid        = '0;
        req_data[23:16]  = 8'h00;
        tx_busy          = 1'b1;
        repeat (4) tick();
        tx_busy = 1'b0;
        repeat (4) tick();
        chk("hold_tx_data", {24'h0, tx_data}, 32'hC3);
        chk("hold_idle", {31'h0, sched_busy}, 32'h0);
        req_data = c_DATA;

        // A busy transmitter while the scheduler is idle blocks the grant
        tx_busy   = 1'b1;
        req_valid = 4'b0100;
        cnt       = 0;
        repeat (6) begin
            tick();
            if (tx_data_valid !== 1'b0) cnt++;
        end
        chk("busy_block_pulses", cnt, 0);
        chk("busy_block_idle", {31'h0, sched_busy}, 32'h0);
        tx_busy = 1'b0;
        wait_valid(lat);
        chk("busy_block_lat", lat, 1);
        chk("busy_block_grant", {30'h0, grant_id}, 32'd2);
        finish_frame(3);

        // Reset in WAIT_DONE, then request 3
        req_valid = 4'b0001;
        wait_valid(lat);
        tick();
        tx_busy = 1'b1;
        repeat (2) tick();
        chk("pre_reset_busy", {31'h0, sched_busy}, 32'h1);
        req_valid = 4'b0000;
        rst       = 1'b1;
        #1;
        chk("async_reset_outputs", outs(), 32'h0);
        repeat (2) tick();
        chk("held_reset_outputs", outs(), 32'h0);
        tx_busy   = 1'b0;
        req_valid = 4'b1000;
        rst       = 1'b0;
        wait_valid(lat);
        chk("post_reset_lat", lat, 1);
        chk("post_reset_grant", {30'h0, grant_id}, 32'd3);
        chk("post_reset_data", {24'h0, tx_data}, 32'hD4);
        chk("post_reset_ready", {28'h0, req_ready}, 32'h8);
        finish_frame(2);

        // Reset clears the round-robin pointer (it would start at 1 otherwise)
        req_valid = 4'b0001;
        wait_valid(lat);
        finish_frame(2);
        rst = 1'b1;
        tick();
        rst       = 1'b0;
        req_valid = 4'b1001;
        wait_valid(lat);
        chk("ptr_reset_grant", {30'h0, grant_id}, 32'd0);
        finish_frame(2);

        // Transmitter never goes busy
        req_valid = 4'b0001;
        wait_valid(lat);
        req_valid = 4'b0000;
`ifdef UART_TX_SCHED_TIMEOUT_EN
        cnt = 0;
        while (timeout_err !== 1'b1 && cnt < 200) begin
            tick();
            cnt++;
        end
        chk("timeout_delay", cnt, 64);
        chk("timeout_idle", {31'h0, sched_busy}, 32'h0);
        tick();
        chk("timeout_pulse_width", {31'h0, timeout_err}, 32'h0);
        req_valid = 4'b0010;
        wait_valid(lat);
        chk("timeout_next_grant", {30'h0, grant_id}, 32'd1);
        finish_frame(2);
`else
        bad_to = 0;
        bad_sb = 0;
        repeat (100) begin
            tick();
            if (timeout_err !== 1'b0) bad_to++;
            if (sched_busy !== 1'b1) bad_sb++;
        end
        chk("no_timeout_err", bad_to, 0);
        chk("no_timeout_busy", bad_sb, 0);
        finish_frame(2);
        chk("no_timeout_recover", {31'h0, sched_busy}, 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule : tb_uart_tx_sched
`default_nettype wire
